// File: rtl/pio_read_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency PIO read slave.
// Define PIO_ARB_CHANGE_IRQ_EN for idle polling and the change interrupt.
module pio_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         slv_address,
    input  logic [DATA_W-1:0]         slv_readdata,
    output logic                      change_irq,
    input  logic                      irq_clear
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [ADDR_W-1:0]  r_slv_address;
    logic               r_s1_v;
    logic [PTR_W-1:0]   r_s1_id;
    logic               r_s2_v;
    logic [PTR_W-1:0]   r_s2_id;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;

    logic               w_found;
    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W-1:0]   w_scan;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [NUM_REQ-1:0] w_grant;
    logic [ADDR_W-1:0]  w_addr;

    // Circular search from r_rr_ptr; w_scan wraps at NUM_REQ-1.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        w_scan   = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
            w_scan = (w_scan == LAST_ID) ? '0 : w_scan + 1'b1;
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found) begin
            w_grant[w_winner] = 1'b1;
        end
    end

    assign w_next_ptr = (w_winner == LAST_ID) ? '0 : w_winner + 1'b1;
    assign w_addr     = req_addr[w_winner*ADDR_W +: ADDR_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr      <= '0;
            r_slv_address <= '0;
            r_s1_v        <= 1'b0;
            r_s1_id       <= '0;
            r_s2_v        <= 1'b0;
            r_s2_id       <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
        end else begin
            if (w_found) begin
                r_rr_ptr      <= w_next_ptr;
                r_slv_address <= w_addr;
                r_s1_v        <= 1'b1;
                r_s1_id       <= w_winner;
            end else begin
                r_s1_v <= 1'b0;
`ifdef PIO_ARB_CHANGE_IRQ_EN
                r_slv_address <= '0;
`endif
            end
            r_s2_v      <= r_s1_v;
            r_s2_id     <= r_s1_id;
            r_rsp_valid <= '0;
            if (r_s2_v) begin
                r_rsp_valid[r_s2_id] <= 1'b1;
                r_rsp_data           <= slv_readdata;
            end
        end
    end

`ifdef PIO_ARB_CHANGE_IRQ_EN
    // chk marks reads of address 0: idle polls and requester reads alike.
    logic              r_s1_chk;
    logic              r_s2_chk;
    logic [DATA_W-1:0] r_last_sample;
    logic              r_change_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_chk      <= 1'b0;
            r_s2_chk      <= 1'b0;
            r_last_sample <= '0;
            r_change_irq  <= 1'b0;
        end else begin
            r_s1_chk <= w_found ? (w_addr == '0) : 1'b1;
            r_s2_chk <= r_s1_chk;
            if (r_s2_chk && (slv_readdata != r_last_sample)) begin
                r_last_sample <= slv_readdata;
                r_change_irq  <= 1'b1;
            end else if (irq_clear) begin
                r_change_irq <= 1'b0;
            end
        end
    end

    assign change_irq = r_change_irq;
`else
    logic w_unused_irq_clear;
    assign w_unused_irq_clear = irq_clear;
    assign change_irq         = 1'b0;
`endif

    assign req_ready   = w_grant;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign slv_address = r_slv_address;

endmodule

// File: tb/tb_pio_read_arbiter.sv
// Bench for pio_read_arbiter: directed steps plus random traffic
// against a queue-based reference of the arbitration and read rules.
module tb_pio_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = 32;
`ifdef PIO_ARB_CHANGE_IRQ_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] slv_address;
    logic [DW-1:0] slv_readdata = '0;
    logic          change_irq;
    logic          irq_clear;
    logic [DW-1:0] in_port;

    pio_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .slv_address  (slv_address),
        .slv_readdata (slv_readdata),
        .change_irq   (change_irq),
        .irq_clear    (irq_clear)
    );

    always #5 clk = ~clk;

    // PIO slave: address 0 returns in_port, others read as zero.
    always_ff @(posedge clk)
        slv_readdata <= (slv_address == '0) ? in_port : '0;

    typedef struct {
        int c;
        int id;
        int addr;
    } rd_t;

    rd_t           q[$];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    int            m_ptr = 0;
    logic [N-1:0]  m_rsp_v = '0;
    logic [DW-1:0] m_rsp_d = '0;
    logic [DW-1:0] m_last = '0;
    logic          m_irq = 1'b0;
    logic [DW-1:0] hist [0:4095];

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int            win;
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  nv;
        logic [DW-1:0] d;
        rd_t           e;
        @(negedge clk);
        hist[cyc] = in_port;
        if (!reset_n) begin
            chk("rst_rsp_valid", DW'(rsp_valid), '0);
            chk("rst_rsp_data", rsp_data, '0);
            chk("rst_change_irq", DW'(change_irq), '0);
            chk("rst_slv_address", DW'(slv_address), '0);
            q.delete();
            m_ptr   = 0;
            m_rsp_v = '0;
            m_rsp_d = '0;
            m_last  = '0;
            m_irq   = 1'b0;
        end else begin
            win = -1;
            for (int k = 0; k < N; k++) begin
                int i = (m_ptr + k) % N;
                if (win < 0 && req_valid[i]) win = i;
            end
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("req_ready", DW'(req_ready), DW'(exp_rdy));
            chk("rsp_valid", DW'(rsp_valid), DW'(m_rsp_v));
            chk("rsp_data", rsp_data, m_rsp_d);
            chk("change_irq", DW'(change_irq), DW'(m_irq));
            if (win >= 0) begin
                e.c    = cyc;
                e.id   = win;
                e.addr = int'(req_addr[win*AW +: AW]);
                q.push_back(e);
                m_ptr = (win + 1) % N;
            end else if (FEAT) begin
                e.c    = cyc;
                e.id   = -1;
                e.addr = 0;
                q.push_back(e);
            end
            nv = '0;
            if (q.size() > 0 && q[0].c == cyc - 2) begin
                e = q.pop_front();
                d = (e.addr == 0) ? hist[cyc-1] : '0;
                if (e.id >= 0) begin
                    nv[e.id] = 1'b1;
                    m_rsp_d  = d;
                end
                if (FEAT && e.addr == 0 && d != m_last) begin
                    m_irq  = 1'b1;
                    m_last = d;
                end else if (FEAT && irq_clear) begin
                    m_irq = 1'b0;
                end
            end else if (FEAT && irq_clear) begin
                m_irq = 1'b0;
            end
            m_rsp_v = nv;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        irq_clear = 1'b0;
        in_port   = '0;
        repeat (3) cycle();
        reset_n = 1'b1;

        // all requesters valid: grants rotate from 0
        in_port   = 32'h12345678;
        req_valid = 4'hF;
        repeat (8) cycle();
        req_valid = '0;
        repeat (4) cycle();

        // single read of address 0
        in_port   = 32'hDEADBEEF;
        req_valid = 4'b0001;
        req_addr  = '0;
        cycle();
        req_valid = '0;
        repeat (5) cycle();

        // non-zero address reads as zero
        in_port   = 32'hFFFFFFFF;
        req_valid = 4'b0100;
        req_addr  = 8'b0001_0000;
        cycle();
        req_valid = '0;
        repeat (4) cycle();

        // back-to-back reads with in_port changing every cycle
        req_addr  = '0;
        req_valid = 4'b0010;
        in_port   = 32'h1;
        cycle();
        in_port = 32'h2;
        cycle();
        in_port = 32'h3;
        cycle();
        req_valid = '0;
        in_port   = 32'h4;
        repeat (4) cycle();

        // reset with a read in flight
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        reset_n   = 1'b0;
        cycle();
        reset_n   = 1'b1;
        in_port   = '0;
        req_valid = 4'hF;
        cycle();
        req_valid = '0;
        repeat (6) cycle();

        // change interrupt while idle, then clear
        in_port = 32'h5;
        repeat (5) cycle();
        chk("irq_raised", DW'(change_irq), DW'(FEAT));
        irq_clear = 1'b1;
        cycle();
        irq_clear = 1'b0;
        chk("irq_cleared", DW'(change_irq), '0);
        repeat (3) cycle();

        // random traffic
        repeat (1500) begin
            req_valid = N'($urandom);
            req_addr  = (N*AW)'($urandom);
            if ($urandom_range(0, 3) == 0) in_port = $urandom_range(0, 3);
            irq_clear = ($urandom_range(0, 7) == 0);
            reset_n   = ($urandom_range(0, 199) != 0);
            cycle();
        end
        reset_n   = 1'b1;
        req_valid = '0;
        irq_clear = 1'b0;
        repeat (5) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pio_read_arbiter.md
Name: pio_read_arbiter

Overview:
- Shares one read-only PIO Avalon-MM slave among NUM_REQ internal requesters.
- The slave has fixed 1-cycle registered read latency: the address is presented in cycle N and readdata is valid in cycle N+1.
- Round-robin arbitration with a valid/ready request handshake and a one-hot response strobe. Fully pipelined: throughput is one read per clock.
- Sits between the HPS-side/user logic requesters and the PIO slave in the Qsys-generated system.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 2, slave word-address width.
- DATA_W, 32, slave readdata width.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- req_valid, in, NUM_REQ, per-requester read request.
- req_addr, in, NUM_REQ*ADDR_W, per-requester address; slice i is [i*ADDR_W +: ADDR_W].
- req_ready, out, NUM_REQ, one-hot grant, combinational; a handshake occurs when req_valid[i] and req_ready[i] are both high.
- rsp_valid, out, NUM_REQ, one-hot registered response strobe, one cycle wide.
- rsp_data, out, DATA_W, registered response data, shared by all requesters.
- slv_address, out, ADDR_W, registered address to the slave.
- slv_readdata, in, DATA_W, slave readdata.
- change_irq, out, 1, sticky change interrupt (optional feature).
- irq_clear, in, 1, single-cycle clear for change_irq (optional feature).

Behaviour:
- Reset: everything below is asserted asynchronously while reset_n is low.
  - rr_ptr = 0.
  - slv_address = 0.
  - Pipeline valids s1_v, s2_v = 0.
  - rsp_valid = 0, rsp_data = 0, change_irq = 0, last_sample = 0.
- Arbitration (combinational, cycle t):
  - Winner = first i with req_valid[i], searching circularly from rr_ptr upward.
  - req_ready = onehot(winner) when any request is valid, else 0.
  - A requester sees ready only while it asserts valid.
- rr_ptr update: on a handshake, rr_ptr <= (winner+1) mod NUM_REQ. Otherwise it holds.
- Pipeline:
  - Edge ending cycle t: slv_address <= req_addr[winner], s1_v <= 1, s1_id <= winner. With no handshake, s1_v <= 0 and slv_address holds.
  - Edge ending t+1: s2_v <= s1_v, s2_id <= s1_id. The slave registers readdata on the same edge.
  - Edge ending t+2: rsp_data <= slv_readdata, rsp_valid <= s2_v ? onehot(s2_id) : 0.
  - Result: the response is visible in cycle t+3, three cycles after the handshake.
  - rsp_data holds its last value when rsp_valid = 0.
- Back-to-back: one handshake per cycle is sustainable. Responses return in handshake order, one per cycle, with no gaps added.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ-1 grants.
- Requester changing req_addr while valid and not ready: allowed. The address sampled is the one present in the handshake cycle.
- Reset mid-operation: in-flight requests are dropped. No rsp_valid is produced for them after reset_n deasserts.
- The first handshake is legal in the first cycle after reset deassertion.

Optional Feature:
- Macro: PIO_ARB_CHANGE_IRQ_EN.
- Defined:
  - In any cycle with req_valid == 0, the block issues a background poll of address 0 through the same pipeline, tagged internal; rsp_valid stays 0 for it.
  - On the poll result, if slv_readdata != last_sample, change_irq <= 1 and last_sample <= slv_readdata.
  - irq_clear = 1 sets change_irq <= 0, except that a change detected on the same edge wins and keeps change_irq = 1.
  - Requester reads of address 0 also update last_sample and may raise change_irq.
  - Polls never delay requesters: a poll is issued only in idle cycles.
- Not defined:
  - No background polls; slv_address holds when idle.
  - change_irq is tied 0 and irq_clear is ignored. Ports remain present.

Test Plan:
- Single read: req_valid=4'b0001, addr 0, slave in_port=0xDEADBEEF → req_ready[0] high the same cycle; rsp_valid=4'b0001 with rsp_data=0xDEADBEEF exactly 3 cycles later, for one cycle.
- Round robin: all four valid for 8 cycles, in_port constant 0x12345678 → grants 0,1,2,3,0,1,2,3; rsp_valid walks the same one-hot sequence, delayed 3 cycles, one per cycle.
- Address gating: requester 2 reads addr 1 while in_port=0xFFFFFFFF → rsp_data=0x00000000.
- Pipelined ordering: in_port changes every cycle (0x1, 0x2, 0x3); requester 1 handshakes on three consecutive cycles → three responses of 0x1, 0x2, 0x3 in order.
- Reset mid-flight: handshake at t, reset_n low at t+1 for 1 cycle → no rsp_valid ever for that request; rr_ptr back to 0, so requester 0 wins next.
- Change IRQ (feature on): idle, in_port goes 0x0→0x5 → change_irq=1 within 4 cycles. Then irq_clear pulse with in_port stable → change_irq=0. Feature off → change_irq stays 0.
